// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the pipeline stage buffer.
//   pipe_state_e    : stage buffer FSM state (EMPTY, FULL, SKID)
//   RV_NOP          : RV32I canonical NOP (addi x0, x0, 0)
//   idex_t/exmem_t  : packed stage bundles, with *_NOP payloads for NOP_PAYLOAD
//   state_occupancy : number of valid entries held in a given state
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_e;

   localparam logic [31:0] RV_NOP = 32'h00000013;

   // ID/EX bundle, 160 bits wide so it matches the default DATA_W.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [23:0] imm;
      logic [4:0]  rd;
      logic        reg_wr;
      logic        start;
      logic        mem_wr;
   } idex_t;

   localparam idex_t IDEX_NOP = '{
      instr:   RV_NOP,
      pc:      32'h0,
      rs1_val: 32'h0,
      rs2_val: 32'h0,
      imm:     24'h0,
      rd:      5'h0,
      reg_wr:  1'b0,
      start:   1'b0,
      mem_wr:  1'b0
   };

   // EX/MEM bundle.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] alu_res;
      logic [31:0] store_data;
      logic [4:0]  rd;
      logic        reg_wr;
      logic        mem_wr;
      logic        mem_rd;
   } exmem_t;

   localparam exmem_t EXMEM_NOP = '{
      instr:      RV_NOP,
      pc:         32'h0,
      alu_res:    32'h0,
      store_data: 32'h0,
      rd:         5'h0,
      reg_wr:     1'b0,
      mem_wr:     1'b0,
      mem_rd:     1'b0
   };

   function automatic logic [1:0] state_occupancy(input pipe_state_e s);
      logic [1:0] occ;
      occ = 2'd0;
      case (s)
         FULL:    occ = 2'd1;
         SKID:    occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: one valid+data register pair.
//   clk, rst      : clock, synchronous active-high reset
//   clear         : drop contents (valid=0, data=RST_DATA); wins over load
//   load          : capture load_data, valid=1
//   unload        : valid=0, data held (ignored when load is set)
//   load_data     : payload to capture
//   valid, data   : slot contents
module pipe_skid_slot #(
   parameter int                DATA_W   = 160,
   parameter logic [DATA_W-1:0] RST_DATA = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic              unload,
   input  logic [DATA_W-1:0] load_data,
   output logic              valid,
   output logic [DATA_W-1:0] data
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         valid <= 1'b0;
         data  <= RST_DATA;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (unload) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic pipeline stage register with valid/ready handshake,
// stall (out_ready=0) and flush (inject NOP_PAYLOAD).
//
// Handshake: a beat moves on a port in every cycle where valid & ready are both
// high at the clock edge; valid never depends on ready, data is stable while
// valid is high and ready is low.
//
// Build option: define PIPE_SKID_EN for a second (skid) entry. With it, in_ready
// comes straight from the skid valid flop (no combinational path from
// out_ready) and the stage keeps full throughput under back-pressure.
// Without it, in_ready = !out_valid | out_ready and only one entry exists.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   flush                 : kill stage contents next cycle
//   in_valid/in_ready     : upstream handshake, in_data payload
//   out_valid/out_ready   : downstream handshake, out_data payload
//   occupancy             : entries held (0..1, or 0..2 with PIPE_SKID_EN)
//   bubble_cnt            : saturating count of out_ready & !out_valid cycles
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int                DATA_W      = 160,
   parameter logic [DATA_W-1:0] NOP_PAYLOAD = '0,
   parameter int                CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  bubble_cnt
);

   pipe_state_e       state;
   pipe_state_e       state_next;
   logic              main_valid;
   logic              main_load;
   logic              main_unload;
   logic [DATA_W-1:0] main_load_data;
   logic [DATA_W-1:0] skid_data;
   logic              accept;
   logic              drain;

   assign out_valid = main_valid;
   assign drain     = main_valid & out_ready;
   assign accept    = in_valid & in_ready;

`ifdef PIPE_SKID_EN
   logic skid_valid;
   logic skid_load;
   logic skid_unload;

   assign in_ready = !skid_valid;

   pipe_skid_slot #(
      .DATA_W   (DATA_W),
      .RST_DATA (NOP_PAYLOAD)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .load      (skid_load),
      .unload    (skid_unload),
      .load_data (in_data),
      .valid     (skid_valid),
      .data      (skid_data)
   );
`else
   assign in_ready  = !main_valid | out_ready;
   // No skid entry: the SKID branch below can never be entered.
   assign skid_data = NOP_PAYLOAD;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next     = state;
      main_load      = 1'b0;
      main_unload    = 1'b0;
      main_load_data = in_data;
`ifdef PIPE_SKID_EN
      skid_load      = 1'b0;
      skid_unload    = 1'b0;
`endif
      case (state)
         EMPTY: begin
            if (accept) begin
               main_load  = 1'b1;
               state_next = FULL;
            end
         end
         FULL: begin
            if (drain && accept) begin
               main_load = 1'b1;
            end else if (drain) begin
               main_unload = 1'b1;
               state_next  = EMPTY;
            end
`ifdef PIPE_SKID_EN
            else if (accept) begin
               // Downstream stalled: park the new beat in the skid entry.
               skid_load  = 1'b1;
               state_next = SKID;
            end
`endif
         end
         SKID: begin
            // in_ready is low here, so the only move is skid -> main.
            if (drain) begin
               main_load      = 1'b1;
               main_load_data = skid_data;
`ifdef PIPE_SKID_EN
               skid_unload    = 1'b1;
`endif
               state_next     = FULL;
            end
         end
         default: state_next = EMPTY;
      endcase
      // Flush clears both slots through their clear input; any beat accepted
      // this cycle is discarded, a drain this cycle still completes.
      if (flush) begin
         state_next = EMPTY;
      end
   end

   pipe_skid_slot #(
      .DATA_W   (DATA_W),
      .RST_DATA (NOP_PAYLOAD)
   ) u_main (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .load      (main_load),
      .unload    (main_unload),
      .load_data (main_load_data),
      .valid     (main_valid),
      .data      (out_data)
   );

   // State is a flop, so occupancy reflects the entries held after the edge.
   assign occupancy = state_occupancy(state);

   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt <= '0;
      end else if (out_ready && !main_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
         bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed, table-driven bench for pipe_stage_buf.
// Expectations adapt to the build: skid-entry behaviour is expected only when
// PIPE_SKID_EN is defined for both bench and design.
module tb_pipe_stage_buf;
   import pipe_pkg::*;

   localparam int DATA_W = 160;
   localparam int CNT_W  = 16;
   localparam logic [DATA_W-1:0] NOP = IDEX_NOP;
`ifdef PIPE_SKID_EN
   localparam logic SK = 1'b1;
`else
   localparam logic SK = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  bubble_cnt;

   int total = 0;
   int bad   = 0;

   pipe_stage_buf #(
      .DATA_W      (DATA_W),
      .NOP_PAYLOAD (NOP),
      .CNT_W       (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .occupancy  (occupancy),
      .bubble_cnt (bubble_cnt)
   );

   // ---- clock ----
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---- vector table ----
   typedef struct {
      logic              iv;
      logic [DATA_W-1:0] d;
      logic              ordy;
      logic              fl;
      logic              e_irdy;
      logic              e_ov;
      logic              chk_d;
      logic [DATA_W-1:0] e_od;
      logic [1:0]        e_occ;
   } vec_t;

   vec_t vecs[$];

   // Payload with the tag byte at both ends and a derived pattern in between.
   function automatic logic [DATA_W-1:0] mk(input logic [7:0] b);
      return {b, {18{b ^ 8'h5a}}, b};
   endfunction

   function automatic void add(input logic iv, input logic [DATA_W-1:0] d,
                               input logic ordy, input logic fl,
                               input logic e_irdy, input logic e_ov,
                               input logic chk_d, input logic [DATA_W-1:0] e_od,
                               input logic [1:0] e_occ);
      vec_t v;
      v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
      v.e_irdy = e_irdy; v.e_ov = e_ov; v.chk_d = chk_d;
      v.e_od = e_od; v.e_occ = e_occ;
      vecs.push_back(v);
   endfunction

   // ---- scoreboard compare ----
   task automatic chk(input string name, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---- driver tasks (called at posedge+1) ----
   task automatic drive(input logic iv, input logic [DATA_W-1:0] d,
                        input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v, input int idx);
      drive(v.iv, v.d, v.ordy, v.fl);
      #1;
      chk($sformatf("v%0d in_ready", idx), in_ready, v.e_irdy);
      tick();
      chk($sformatf("v%0d out_valid", idx), out_valid, v.e_ov);
      chk($sformatf("v%0d occupancy", idx), occupancy, v.e_occ);
      if (v.chk_d) chk($sformatf("v%0d out_data", idx), out_data, v.e_od);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, " out_valid"}, out_valid, 1'b0);
      chk({tag, " out_data"}, out_data, NOP);
      chk({tag, " occupancy"}, occupancy, 2'd0);
      chk({tag, " bubble_cnt"}, bubble_cnt, '0);
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0);

      // ---- table: iv, data, out_ready, flush | in_ready, ov, chk, od, occ ----
      add(1, mk(8'hA1), 1, 0,  1, 1, 1, mk(8'hA1), 1);
      add(1, mk(8'hA2), 1, 0,  1, 1, 1, mk(8'hA2), 1);
      add(1, mk(8'hA3), 1, 0,  1, 1, 1, mk(8'hA3), 1);
      add(0, '0,        1, 0,  1, 0, 0, '0,        0);
      add(1, mk(8'hB1), 0, 0,  1, 1, 1, mk(8'hB1), 1);
      add(1, mk(8'hB2), 0, 0,  SK, 1, 1, mk(8'hB1), SK ? 2'd2 : 2'd1);
      for (int i = 0; i < 3; i++)
         add(1, mk(8'hB2), 0, 0, 0, 1, 1, mk(8'hB1), SK ? 2'd2 : 2'd1);
      add(0, '0,        1, 0,  !SK, SK, SK, mk(8'hB2), SK ? 2'd1 : 2'd0);
      add(0, '0,        1, 0,  1, 0, 0, '0,        0);
      add(1, mk(8'hC1), 0, 0,  1, 1, 1, mk(8'hC1), 1);
      add(1, mk(8'hC2), 0, 0,  SK, 1, 1, mk(8'hC1), SK ? 2'd2 : 2'd1);
      add(1, mk(8'hC3), 1, 1,  !SK, 0, 1, NOP,      0);
      add(0, '0,        1, 0,  1, 0, 0, '0,        0);
      add(1, mk(8'hD1), 1, 0,  1, 1, 1, mk(8'hD1), 1);
      add(1, mk(8'hD2), 1, 0,  1, 1, 1, mk(8'hD2), 1);
      add(0, '0,        0, 1,  SK, 0, 1, NOP,      0);
      add(0, '0,        1, 0,  1, 0, 0, '0,        0);

      // ---- initial reset ----
      tick();
      tick();
      check_reset_state("rst0");
      rst = 1'b0;

      foreach (vecs[i]) apply(vecs[i], i);

      // ---- in_ready vs out_ready in the same cycle while FULL ----
      drive(1'b1, mk(8'hE1), 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("full stall in_ready", in_ready, SK);
      out_ready = 1'b1;
      #1;
      chk("full go in_ready", in_ready, 1'b1);
      out_ready = 1'b0;

      // ---- reset held 2 cycles mid-traffic ----
      drive(1'b1, mk(8'hE2), 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      check_reset_state("rst1a");
      tick();
      check_reset_state("rst1b");
      rst = 1'b0;

      // ---- bubble counter ----
      drive(1'b0, '0, 1'b1, 1'b0);
      repeat (5) tick();
      chk("bubble idle5", bubble_cnt, 16'd5);
      drive(1'b0, '0, 1'b1, 1'b1);
      tick();
      chk("bubble flush", bubble_cnt, 16'd6);
      drive(1'b0, '0, 1'b0, 1'b0);
      repeat (3) tick();
      chk("bubble no ready", bubble_cnt, 16'd6);
      drive(1'b1, mk(8'hF1), 1'b1, 1'b0);
      tick();
      chk("bubble load", bubble_cnt, 16'd7);
      chk("bubble load ov", out_valid, 1'b1);
      chk("bubble load od", out_data, mk(8'hF1));
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
      chk("bubble valid", bubble_cnt, 16'd7);
      repeat (65527) tick();
      chk("bubble near sat", bubble_cnt, 16'hFFFE);
      tick();
      chk("bubble sat", bubble_cnt, 16'hFFFF);
      repeat (5000) tick();
      chk("bubble hold sat", bubble_cnt, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
